// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller:
//            controller state encoding and EX operand forward-select codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Controller states. The encoding is fixed so that state dumps are stable.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hz_state_e;

  // EX operand forward selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : Forward-select for one EX source operand. The youngest producer
//            (EX/MEM) wins over the older one (MEM/WB); x0 never forwards.
// Ports    : ex_rs   - source register of the operand in ID/EX
//            mem_rd  - EX/MEM destination, mem_we - EX/MEM write enable
//            wb_rd   - MEM/WB destination, wb_we  - MEM/WB write enable
//            sel     - FWD_MEM / FWD_WB / FWD_RF
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int RF_ADDRESS = 5
) (
  input  logic [RF_ADDRESS-1:0] ex_rs,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic                  mem_we,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  wb_we,
  output logic [1:0]            sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_we && (mem_rd != '0) && (mem_rd == ex_rs);
  assign w_wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  always_comb begin
    sel = FWD_RF;
    if (w_mem_hit) begin
      sel = FWD_MEM;
    end else if (w_wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard, forwarding, stall/flush and halt controller for the
//            5-stage RV32 pipeline. Drives pipeline register enables, flushes
//            and the EX/MEM bubble, the EX operand forward selects, a halt
//            indication and two saturating performance counters.
// Ports    : clk, reset (synchronous, active-high)
//            id_rs1/id_rs2(+_used)  - sources of the instruction in ID
//            ex_rs1/ex_rs2/ex_rd    - registers of the instruction in ID/EX
//            ex_mem_read/ex_multicycle/ex_halt - ID/EX control bits
//            br_taken               - branch redirect
//            mem_rd/mem_reg_write, wb_rd/wb_reg_write - later-stage writers
//            pc_en/ifid_en/idex_en, ifid_flush/idex_flush, exmem_bubble
//            fwd_a/fwd_b, halted, stall_cnt/flush_cnt
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int MC_STALL   = 3,   // 2..15
  parameter int HALT_DRAIN = 2,   // 1..7
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RF_ADDRESS-1:0] ex_rs1,
  input  logic [RF_ADDRESS-1:0] ex_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_multicycle,
  input  logic                  ex_halt,
  input  logic                  br_taken,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // The first stall cycle is spent in RUN, so MC_WAIT covers the remainder.
  localparam logic [3:0]       MC_LOAD    = 4'(MC_STALL - 1);
  localparam logic [2:0]       DRAIN_LOAD = 3'(HALT_DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  hz_state_e        state_q, state_d;
  logic [3:0]       mc_cnt_q, mc_cnt_d;
  logic             mc_done_q, mc_done_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             halted_q, halted_d;

  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_load_use;
  logic             w_stall_inc;
  logic             w_flush_inc;

  fwd_sel #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_a (
    .ex_rs  (ex_rs1),
    .mem_rd (mem_rd),
    .mem_we (mem_reg_write),
    .wb_rd  (wb_rd),
    .wb_we  (wb_reg_write),
    .sel    (w_fwd_a)
  );

  fwd_sel #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_b (
    .ex_rs  (ex_rs2),
    .mem_rd (mem_rd),
    .mem_we (mem_reg_write),
    .wb_rd  (wb_rd),
    .wb_we  (wb_reg_write),
    .sel    (w_fwd_b)
  );

  // A load in EX cannot forward in time to a consumer sitting in ID.
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    mc_done_d    = mc_done_q;
    drain_cnt_d  = drain_cnt_q;
    halted_d     = halted_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    fwd_a        = w_fwd_a;
    fwd_b        = w_fwd_b;

    case (state_q)
      RUN: begin
        if (ex_halt) begin
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = DRAIN;
        end else if (ex_multicycle && !mc_done_q) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          mc_cnt_d     = MC_LOAD;
          state_d      = MC_WAIT;
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        // Once ID/EX advances, the completed multi-cycle op has left EX.
        if (idex_en) begin
          mc_done_d = 1'b0;
        end
      end

      MC_WAIT: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
        if (mc_cnt_q == 4'd1) begin
          state_d   = RUN;
          mc_done_d = 1'b1;
        end else begin
          mc_cnt_d = mc_cnt_q - 4'd1;
        end
      end

      DRAIN: begin
        // EX/MEM keeps loading so the older instructions retire.
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (drain_cnt_q == 3'd0) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end

      HALTED: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_bubble = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    w_stall_inc = !pc_en && ((state_q == RUN) || (state_q == MC_WAIT));

    if (w_stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (w_flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Hold the pipeline empty while reset is asserted.
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mc_cnt_q    <= 4'd0;
      mc_done_q   <= 1'b0;
      drain_cnt_q <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      mc_done_q   <= mc_done_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Inputs change on the
//            falling edge; outputs are sampled 1 ns later and compared with a
//            cycle-level behavioural model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int RF_ADDRESS = 5;
  localparam int MC_STALL   = 3;
  localparam int HALT_DRAIN = 2;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_multicycle, ex_halt;
  logic       br_taken, mem_reg_write, wb_reg_write;

  wire             pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble;
  wire [1:0]       fwd_a, fwd_b;
  wire             halted;
  wire [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .RF_ADDRESS (RF_ADDRESS),
    .MC_STALL   (MC_STALL),
    .HALT_DRAIN (HALT_DRAIN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_multicycle (ex_multicycle),
    .ex_halt       (ex_halt),
    .br_taken      (br_taken),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_bubble  (exmem_bubble),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .halted        (halted),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, fwd_a, fwd_b, halted}
  wire [10:0]        obs_ctl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
                                exmem_bubble, fwd_a, fwd_b, halted};
  wire [2*CNT_W-1:0] obs_cnt = {stall_cnt, flush_cnt};

  // ---------------- behavioural model ----------------
  int   m_stall, m_flush;   // counter values
  int   m_mc_left;          // remaining multi-cycle stall cycles after the first
  int   m_drain_left;       // remaining drain cycles
  bit   m_halted;
  bit   m_done;             // the op now in EX already had its stall
  logic [10:0]        exp_ctl;
  logic [2*CNT_W-1:0] exp_cnt;

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Produces the expected outputs for the current inputs, then advances the
  // model by one clock.
  task automatic model_cycle();
    logic [1:0] fa, fb;
    bit         lu;
    fa = fwd_of(ex_rs1);
    fb = fwd_of(ex_rs2);
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    exp_cnt = {CNT_W'(m_stall), CNT_W'(m_flush)};
    if (reset) begin
      exp_ctl = {6'b000111, 4'b0000, m_halted};
      m_stall = 0; m_flush = 0; m_mc_left = 0; m_drain_left = 0;
      m_halted = 0; m_done = 0;
    end else if (m_halted) begin
      exp_ctl = {6'b000111, fa, fb, 1'b1};
    end else if (m_drain_left > 0) begin
      exp_ctl = {6'b011110, fa, fb, 1'b0};
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (m_mc_left > 0) begin
      exp_ctl = {6'b000001, fa, fb, 1'b0};
      m_stall = sat(m_stall + 1);
      m_mc_left--;
      if (m_mc_left == 0) m_done = 1;
    end else if (ex_halt) begin
      exp_ctl = {6'b011110, fa, fb, 1'b0};
      m_stall = sat(m_stall + 1);
      m_drain_left = HALT_DRAIN;
      m_done = 0;
    end else if (ex_multicycle && !m_done) begin
      exp_ctl = {6'b000001, fa, fb, 1'b0};
      m_stall = sat(m_stall + 1);
      m_mc_left = MC_STALL - 1;
    end else if (br_taken) begin
      exp_ctl = {6'b111110, fa, fb, 1'b0};
      m_flush = sat(m_flush + 1);
      m_done = 0;
    end else if (lu) begin
      exp_ctl = {6'b001010, fa, fb, 1'b0};
      m_stall = sat(m_stall + 1);
      m_done = 0;
    end else begin
      exp_ctl = {6'b111000, fa, fb, 1'b0};
      m_done = 0;
    end
  endtask

  task automatic clear_inputs();
    reset = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_mem_read = 0; ex_multicycle = 0; ex_halt = 0; br_taken = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #1 model_cycle();  // DUT registers are unknown until this first reset edge
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL reset_hold: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      @(negedge clk);
    end
    reset = 0;
    #1 model_cycle();
    if ({pc_en, ifid_en, idex_en, halted, stall_cnt, flush_cnt} !== {4'b1110, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_release: got en=%b%b%b halted=%b stall=%0d flush=%0d, expected en=111 halted=0 stall=0 flush=0",
               pc_en, ifid_en, idex_en, halted, stall_cnt, flush_cnt);
    end
    n_chk++;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      if (i == 0) begin ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; end
      if (i == 2) begin ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; end  // x0 never stalls
      if (i == 3) begin ex_mem_read = 1; ex_rd = 6; id_rs2 = 6; id_rs2_used = 0; end  // unused source
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL load_use_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      if ({pc_en, ifid_en, idex_flush} !== ((i == 0) ? 3'b001 : 3'b110)) begin
        n_fail++;
        $display("FAIL load_use_bubble i=%0d: got pc_en/ifid_en/idex_flush=%b%b%b", i, pc_en, ifid_en, idex_flush);
      end
      n_chk++;
      @(negedge clk);
    end
    #1;
    if (stall_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL load_use_count: got stall_cnt=%0d, expected 1", stall_cnt);
    end
    n_chk++;
    @(negedge clk);
  endtask

  task automatic test_multicycle();
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    clear_inputs();
    for (int i = 0; i <= MC_STALL; i++) begin
      ex_multicycle = 1;
      br_taken = (i == 1);  // must be ignored while waiting
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL mc_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      if ({idex_en, exmem_bubble} !== ((i < MC_STALL) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL mc_stall i=%0d: got idex_en=%b exmem_bubble=%b", i, idex_en, exmem_bubble);
      end
      n_chk++;
      @(negedge clk);
    end
    clear_inputs();
    #1 model_cycle();
    if ({stall_cnt, flush_cnt, pc_en} !== {8'd3, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mc_count: got stall=%0d flush=%0d pc_en=%b, expected stall=3 flush=0 pc_en=1", stall_cnt, flush_cnt, pc_en);
    end
    n_chk++;
    @(negedge clk);
  endtask

  task automatic test_branch();
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      br_taken = (i == 0) || (i == 2);
      if (i == 2) begin ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_rs2_used = 1; end
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL branch_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      if (br_taken && ({ifid_flush, idex_flush, pc_en, ifid_en} !== 4'b1111)) begin
        n_fail++;
        $display("FAIL branch_flush i=%0d: got ifid_flush/idex_flush/pc_en/ifid_en=%b%b%b%b, expected 1111",
                 i, ifid_flush, idex_flush, pc_en, ifid_en);
      end
      n_chk++;
      @(negedge clk);
    end
    #1;
    if ({flush_cnt, stall_cnt} !== {8'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL branch_count: got flush=%0d stall=%0d, expected flush=2 stall=0", flush_cnt, stall_cnt);
    end
    n_chk++;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    // rs, mem_rd, mem_we, wb_rd, wb_we, expected select
    int tab [6][6] = '{'{7, 7, 1, 7, 1, 2}, '{7, 0, 1, 7, 1, 1}, '{0, 0, 1, 0, 1, 0},
                       '{7, 7, 0, 7, 1, 1}, '{7, 3, 1, 4, 1, 0}, '{4, 3, 1, 4, 0, 0}};
    for (int i = 0; i < 12; i++) begin
      int k = i % 6;
      clear_inputs();
      mem_rd = 5'(tab[k][1]); mem_reg_write = tab[k][2][0];
      wb_rd  = 5'(tab[k][3]); wb_reg_write  = tab[k][4][0];
      if (i < 6) begin ex_rs1 = 5'(tab[k][0]); ex_rs2 = 5'(31); end
      else       begin ex_rs2 = 5'(tab[k][0]); ex_rs1 = 5'(31); end
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL fwd_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      if (((i < 6) ? fwd_a : fwd_b) !== 2'(tab[k][5])) begin
        n_fail++;
        $display("FAIL fwd_sel i=%0d: got fwd_a=%b fwd_b=%b, expected select %0d", i, fwd_a, fwd_b, tab[k][5]);
      end
      n_chk++;
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    for (int i = 0; i < 1 + HALT_DRAIN + 8; i++) begin
      clear_inputs();
      ex_halt = (i == 0);
      if (i > 0) begin  // activity after the halt must have no effect
        br_taken = $urandom_range(0, 1); ex_multicycle = $urandom_range(0, 1);
        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
      end
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL halt_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      if (i > 0 && ({halted, pc_en, exmem_bubble, stall_cnt, flush_cnt} !==
                    {(i > HALT_DRAIN), 1'b0, (i > HALT_DRAIN), 8'd1, 8'd0})) begin
        n_fail++;
        $display("FAIL halt_seq i=%0d: got halted=%b pc_en=%b bubble=%b stall=%0d flush=%0d",
                 i, halted, pc_en, exmem_bubble, stall_cnt, flush_cnt);
      end
      n_chk++;
      @(negedge clk);
    end
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    reset = 0;
    #1 model_cycle();
    if ({halted, pc_en, stall_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL halt_exit: got halted=%b pc_en=%b stall=%0d, expected halted=0 pc_en=1 stall=0", halted, pc_en, stall_cnt);
    end
    n_chk++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_mc_wait();
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    clear_inputs();
    ex_multicycle = 1;
    for (int i = 0; i < 3 + MC_STALL + 1; i++) begin
      reset = (i == 2);  // last wait cycle of the first op
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL mc_reset_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      if (i >= 3 && ({idex_en, exmem_bubble} !== ((i < 3 + MC_STALL) ? 2'b01 : 2'b10))) begin
        n_fail++;
        $display("FAIL mc_reset_restall i=%0d: got idex_en=%b exmem_bubble=%b", i, idex_en, exmem_bubble);
      end
      n_chk++;
      if (i == 3 && stall_cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL mc_reset_count: got stall_cnt=%0d, expected 0", stall_cnt);
      end
      n_chk++;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs(); reset = 1;
    #1 model_cycle(); @(negedge clk);
    for (int i = 0; i < 2 * (CNT_MAX + 20); i++) begin
      clear_inputs();
      if (i < CNT_MAX + 20) begin ex_mem_read = 1; ex_rd = 2; id_rs2 = 2; id_rs2_used = 1; end
      else br_taken = 1;
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL sat_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      @(negedge clk);
    end
    clear_inputs();
    #1;
    if ({stall_cnt, flush_cnt} !== {8'hFF, 8'hFF}) begin
      n_fail++;
      $display("FAIL sat_hold: got stall=%0d flush=%0d, expected 255 and 255", stall_cnt, flush_cnt);
    end
    n_chk++;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      reset         = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rs1_used   = $urandom_range(0, 1);
      id_rs2_used   = $urandom_range(0, 1);
      ex_rs1        = 5'($urandom_range(0, 7));
      ex_rs2        = 5'($urandom_range(0, 7));
      ex_rd         = 5'($urandom_range(0, 7));
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_multicycle = ($urandom_range(0, 9) == 0);
      ex_halt       = ($urandom_range(0, 79) == 0);
      br_taken      = ($urandom_range(0, 5) == 0);
      mem_rd        = 5'($urandom_range(0, 7));
      mem_reg_write = $urandom_range(0, 1);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_reg_write  = $urandom_range(0, 1);
      #1 model_cycle();
      if ({obs_ctl, obs_cnt} !== {exp_ctl, exp_cnt}) begin
        n_fail++;
        $display("FAIL random_model i=%0d: got ctl=%b cnt=%h, expected ctl=%b cnt=%h", i, obs_ctl, obs_cnt, exp_ctl, exp_cnt);
      end
      n_chk++;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    m_stall = 0; m_flush = 0; m_mc_left = 0; m_drain_left = 0;
    m_halted = 0; m_done = 0;
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch();
    test_forwarding();
    test_halt();
    test_reset_in_mc_wait();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
